grid_stream_loader: RTL and testbench



---
 rtl/grid_pkg.sv | 21 ++
 rtl/grid_char_decode.sv | 19 +
 rtl/grid_stream_loader.sv | 196 +++++++++++++++++++
 tb/tb_grid_stream_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the grid-matrix interface: ASCII codes, loader states, bit indexing.
package grid_pkg;

    localparam logic [7:0] CH_PAPER = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DONE = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Row r, column c of a packed grid lives at bit r*width+c.
    function automatic int unsigned bit_index(input int unsigned r, input int unsigned c,
                                              input int unsigned width);
        return r * width + c;
    endfunction

endpackage

// File: rtl/grid_char_decode.sv
// Classifies one input byte of the puzzle text into its grid meaning.
module grid_char_decode
    import grid_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_paper,
    output logic       is_empty,
    output logic       is_nl,
    output logic       is_ignore,
    output logic       is_bad
);

    assign is_paper  = (data == CH_PAPER);
    assign is_empty  = (data == CH_EMPTY);
    assign is_nl     = (data == CH_NL);
    assign is_ignore = (data == CH_CR);
    assign is_bad    = !(is_paper || is_empty || is_nl || is_ignore);

endmodule

// File: rtl/grid_stream_loader.sv
// Packs an ASCII '@'/'.' stream into a DEPTH x WIDTH bit grid with valid/ack hand-off.
// Optional GRID_LOADER_POPCOUNT_EN adds a roll_count output counting loaded '@' cells.
module grid_stream_loader
    import grid_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic [WIDTH*DEPTH-1:0]       grid,
    output logic                         grid_valid,
    input  logic                         grid_ack,
    output logic [$clog2(DEPTH+1)-1:0]   rows_loaded,
`ifdef GRID_LOADER_POPCOUNT_EN
    output logic [$clog2(WIDTH*DEPTH+1)-1:0] roll_count,
`endif
    output logic                         err
);

    localparam int N     = WIDTH * DEPTH;
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(DEPTH + 1);
`ifdef GRID_LOADER_POPCOUNT_EN
    localparam int RC_W  = $clog2(N + 1);
`endif

    state_t             state_q, state_d;
    logic [N-1:0]       grid_q, grid_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               grid_valid_q, grid_valid_d;
`ifdef GRID_LOADER_POPCOUNT_EN
    logic [RC_W-1:0]    roll_q, roll_d;
`endif

    logic is_paper, is_empty, is_nl, is_ignore, is_bad;
    logic accept, col_full, bad, clear;
    logic [N-1:0] hit;

    grid_char_decode u_decode (
        .data      (in_data),
        .is_paper  (is_paper),
        .is_empty  (is_empty),
        .is_nl     (is_nl),
        .is_ignore (is_ignore),
        .is_bad    (is_bad)
    );

    assign accept   = in_valid && in_ready_q;
    assign col_full = (col_q == COL_W'(WIDTH));

    // One-hot mask of the cell the current (row, col) cursor points at.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            localparam int unsigned IDX = bit_index(gi, gj, WIDTH);
            assign hit[IDX] = (row_q == ROW_W'(gi)) && (col_q == COL_W'(gj));
        end
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
`ifdef GRID_LOADER_POPCOUNT_EN
        roll_d  = roll_q;
`endif
        bad     = 1'b0;
        clear   = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (is_paper || is_empty) begin
                        if (col_full) begin
                            bad = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                            if (is_paper) begin
                                grid_d = grid_q | hit;
`ifdef GRID_LOADER_POPCOUNT_EN
                                roll_d = roll_q + RC_W'(1);
`endif
                            end
                        end
                    end else if (is_nl) begin
                        if (col_full) begin
                            row_d = row_q + ROW_W'(1);
                            col_d = '0;
                        end else if (col_q != '0 || row_q == '0) begin
                            bad = 1'b1;
                        end
                    end else if (is_bad) begin
                        bad = 1'b1;
                    end

                    // An erroring final byte skips ERR: nothing is left to drain.
                    if (bad) begin
                        err_d = 1'b1;
                        if (in_last) begin
                            clear = 1'b1;
                        end else begin
                            state_d = ERR;
                        end
                    end else if (in_last) begin
                        if (col_d == COL_W'(WIDTH)) begin
                            row_d   = row_d + ROW_W'(1);
                            col_d   = '0;
                            state_d = DONE;
                        end else if (col_d == '0) begin
                            state_d = DONE;
                        end else begin
                            err_d = 1'b1;
                            clear = 1'b1;
                        end
                    end else if (row_d == ROW_W'(DEPTH)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (grid_ack) begin
                    clear   = 1'b1;
                    state_d = LOAD;
                end
            end
            ERR: begin
                if (accept && in_last) begin
                    clear   = 1'b1;
                    state_d = LOAD;
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = LOAD;
            end
        endcase

        if (clear) begin
            grid_d = '0;
            col_d  = '0;
            row_d  = '0;
`ifdef GRID_LOADER_POPCOUNT_EN
            roll_d = '0;
`endif
        end

        in_ready_d   = (state_d != DONE);
        grid_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            grid_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            err_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            grid_valid_q <= 1'b0;
`ifdef GRID_LOADER_POPCOUNT_EN
            roll_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grid_q       <= grid_d;
            col_q        <= col_d;
            row_q        <= row_d;
            err_q        <= err_d;
            in_ready_q   <= in_ready_d;
            grid_valid_q <= grid_valid_d;
`ifdef GRID_LOADER_POPCOUNT_EN
            roll_q       <= roll_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign grid        = grid_q;
    assign grid_valid  = grid_valid_q;
    assign rows_loaded = row_q;
    assign err         = err_q;
`ifdef GRID_LOADER_POPCOUNT_EN
    assign roll_count  = roll_q;
`endif

endmodule

// File: tb/tb_grid_stream_loader.sv
// Randomized self-checking bench for grid_stream_loader (WIDTH=4, DEPTH=3) with a line-level text model.
module tb_grid_stream_loader;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int N     = WIDTH * DEPTH;

    typedef byte bq_t[$];

    logic                          clk;
    logic                          rst_n;
    logic                          in_valid;
    logic                          in_ready;
    logic [7:0]                    in_data;
    logic                          in_last;
    logic [N-1:0]                  grid;
    logic                          grid_valid;
    logic                          grid_ack;
    logic [$clog2(DEPTH+1)-1:0]    rows_loaded;
    logic                          err;
`ifdef GRID_LOADER_POPCOUNT_EN
    logic [$clog2(N+1)-1:0]        roll_count;
`endif

    int checks = 0;
    int errors = 0;

    grid_stream_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .grid        (grid),
        .grid_valid  (grid_valid),
        .grid_ack    (grid_ack),
        .rows_loaded (rows_loaded),
`ifdef GRID_LOADER_POPCOUNT_EN
        .roll_count  (roll_count),
`endif
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: split the text into lines and judge each line as a whole.
    task automatic model(input bq_t f, output bit e, output logic [N-1:0] g,
                         output int rows, output int rolls);
        bq_t line;
        e = 0; g = '0; rows = 0; rolls = 0;
        for (int i = 0; i <= f.size(); i++) begin
            bit end_line;
            end_line = (i == f.size()) || (f[i] == 8'h0A);
            if (i < f.size() && !end_line) begin
                if (f[i] == 8'h40 || f[i] == 8'h2E) line.push_back(f[i]);
                else if (f[i] != 8'h0D) e = 1;
            end else begin
                if (line.size() == 0) begin
                    if (i < f.size() && rows == 0) e = 1;
                end else if (line.size() != WIDTH) begin
                    e = 1;
                end else begin
                    for (int k = 0; k < WIDTH; k++) begin
                        if (line[k] == 8'h40) begin
                            g[rows * WIDTH + k] = 1'b1;
                            rolls++;
                        end
                    end
                    rows++;
                end
                line.delete();
            end
        end
    endtask

    task automatic gen_file(output bq_t f);
        int n, kind, erow, len, badpos;
        bit term;
        f.delete();
        n    = $urandom_range(1, DEPTH);
        kind = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0;
        erow = $urandom_range(0, n - 1);
        term = $urandom_range(0, 1);
        for (int r = 0; r < n; r++) begin
            if (r > 0 && $urandom_range(0, 3) == 0) f.push_back(8'h0A);
            len = WIDTH;
            if (kind == 1 && r == erow) len = $urandom_range(1, WIDTH - 1);
            if (kind == 2 && r == erow) len = WIDTH + 1;
            badpos = $urandom_range(0, len - 1);
            for (int k = 0; k < len; k++) begin
                if (kind == 3 && r == erow && k == badpos) f.push_back(8'h41);
                else f.push_back($urandom_range(0, 1) ? 8'h40 : 8'h2E);
            end
            if ($urandom_range(0, 4) == 0) f.push_back(8'h0D);
            if (r < n - 1 || term) f.push_back(8'h0A);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input byte d, input bit last);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waitc);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_file(input bq_t f, output bit early_valid);
        early_valid = 0;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i == f.size() - 1);
            if (grid_valid && i != f.size() - 1) early_valid = 1;
        end
    endtask

    task automatic do_ack();
        grid_ack = 1'b1;
        @(negedge clk);
        grid_ack = 1'b0;
    endtask

    task automatic check_loaded(input string name, input logic [N-1:0] g_exp,
                                input int r_exp, input int rc_exp, input bit early);
        checks++;
        if (grid_valid !== 1'b1 || early) begin
            errors++;
            $display("FAIL %s_valid: grid_valid=%b early=%b, required 1 and early 0", name, grid_valid, early);
        end
        checks++;
        if (grid !== g_exp) begin
            errors++;
            $display("FAIL %s_grid: got %h, required %h", name, grid, g_exp);
        end
        checks++;
        if (rows_loaded !== r_exp[$clog2(DEPTH+1)-1:0] || err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: rows=%0d err=%b in_ready=%b, required rows=%0d err=0 in_ready=0",
                     name, rows_loaded, err, in_ready, r_exp);
        end
`ifdef GRID_LOADER_POPCOUNT_EN
        checks++;
        if (roll_count !== rc_exp[$clog2(N+1)-1:0]) begin
            errors++;
            $display("FAIL %s_rolls: got %0d, required %0d", name, roll_count, rc_exp);
        end
`else
        if (rc_exp < 0) $display("note: negative roll count %0d", rc_exp);
`endif
    endtask

    task automatic check_idle(input string name, input bit exp_err);
        checks++;
        if (in_ready !== 1'b1 || grid !== '0 || grid_valid !== 1'b0 || rows_loaded !== '0 || err !== exp_err) begin
            errors++;
            $display("FAIL %s: in_ready=%b grid=%h grid_valid=%b rows=%0d err=%b, required 1/0/0/0/%b",
                     name, in_ready, grid, grid_valid, rows_loaded, err, exp_err);
        end
`ifdef GRID_LOADER_POPCOUNT_EN
        checks++;
        if (roll_count !== '0) begin
            errors++;
            $display("FAIL %s_rolls: got %0d, required 0", name, roll_count);
        end
`endif
    endtask

    task automatic test_reset();
        check_idle("reset", 1'b0);
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_basic();
        bq_t f = str2q("@.@@\n....\n@@@@\n");
        bit e, early; logic [N-1:0] g; int r, rc;
        model(f, e, g, r, rc);
        send_file(f, early);
        check_loaded("basic", 12'hF0D, 3, 7, early);
        checks++;
        if (g !== 12'hF0D || r != 3 || e) begin
            errors++;
            $display("FAIL basic_model: model grid %h rows %0d err %b, required f0d 3 0", g, r, e);
        end
        do_ack();
        check_idle("basic_ack", 1'b0);
        $display("test_basic: grid=%h rows=%0d", 12'hF0D, 3);
    endtask

    task automatic test_unterminated();
        bq_t f = str2q("@.@@\n....\n@@@@");
        bit early;
        send_file(f, early);
        check_loaded("unterm", 12'hF0D, 3, 7, early);
        do_ack();
        f = str2q("@..@\n");
        send_file(f, early);
        check_loaded("short_file", 12'h009, 1, 2, early);
        do_ack();
        $display("test_unterminated: full and short files checked");
    endtask

    task automatic test_short_row_err();
        bq_t f = str2q("@@\n");
        bit early;
        send_file(f, early);
        checks++;
        if (err !== 1'b1 || grid_valid !== 1'b0 || early || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_row: err=%b grid_valid=%b early=%b in_ready=%b, required 1 0 0 1",
                     err, grid_valid, early, in_ready);
        end
        send_byte(8'h40, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b after first byte of next file, required 0", err);
        end
        f = str2q("...\n@@@@\n.@..\n");
        send_file(f, early);
        check_loaded("after_err", 12'h2F1, 3, 6, early);
        do_ack();
        $display("test_short_row_err: error then recovery checked");
    endtask

    task automatic test_overflow();
        bq_t f = str2q("@.@.@");
        bq_t rest = str2q("\n....\n@@");
        int not_ready = 0;
        for (int i = 0; i < 4; i++) send_byte(f[i], 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pre: err=%b after four chars, required 0", err);
        end
        send_byte(f[4], 1'b0);
        checks++;
        if (err !== 1'b1 || grid_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err: err=%b grid_valid=%b after fifth char, required 1 0", err, grid_valid);
        end
        for (int i = 0; i < rest.size(); i++) begin
            if (in_ready !== 1'b1) not_ready++;
            send_byte(rest[i], i == rest.size() - 1);
        end
        checks++;
        if (not_ready != 0 || err !== 1'b1 || grid_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: stalls=%0d err=%b grid_valid=%b, required 0 1 0",
                     not_ready, err, grid_valid);
        end
        check_idle("overflow_idle", 1'b1);
        $display("test_overflow: drain of %0d bytes checked", rest.size());
    endtask

    task automatic test_done_hold();
        bq_t f = str2q("@@..\n.@.@\n");
        bit early;
        int bad_cycles = 0;
        send_file(f, early);
        check_loaded("hold_load", 12'h0A3, 2, 4, early);
        in_valid = 1'b1;
        in_data  = 8'h40;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || grid !== 12'h0A3 || grid_valid !== 1'b1 || rows_loaded !== 2'd2) bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0) begin
            errors++;
            $display("FAIL done_hold: %0d cycles with grid/ready disturbed, required 0", bad_cycles);
        end
        in_valid = 1'b0;
        do_ack();
        check_idle("hold_ack", 1'b0);
        $display("test_done_hold: 20 stalled cycles checked");
    endtask

    task automatic test_async_reset();
        bq_t f = str2q("@.@@\n");
        bit early;
        send_file(f, early);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f = str2q("....\n@...\n@@@.\n");
        send_file(f, early);
        check_loaded("post_reset", 12'h710, 3, 4, early);
        do_ack();
        $display("test_async_reset: reset mid-file checked");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bq_t f;
            bit e_exp, early;
            logic [N-1:0] g_exp;
            int r_exp, rc_exp;
            gen_file(f);
            model(f, e_exp, g_exp, r_exp, rc_exp);
            send_file(f, early);
            if (e_exp) begin
                checks++;
                if (err !== 1'b1 || grid_valid !== 1'b0 || early) begin
                    errors++;
                    $display("FAIL random_err[%0d]: err=%b grid_valid=%b early=%b, required 1 0 0",
                             t, err, grid_valid, early);
                end
                $display("random %0d: %0d bytes, malformed", t, f.size());
            end else begin
                check_loaded("random", g_exp, r_exp, rc_exp, early);
                $display("random %0d: %0d bytes, grid=%h rows=%0d", t, f.size(), g_exp, r_exp);
                do_ack();
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        grid_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_unterminated();
        test_short_row_err();
        test_overflow();
        test_done_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
